// File: rtl/norm_pkg.sv
// norm_pkg: shared constants and helpers for the LayerNorm affine back end.
//   DW_DEF / FRAC_DEF / N_DEF : default element width, fractional bits, lane count
//   QMAX / QMIN               : clamp limits at the default element width
//   sat_dw(x, w)              : clamp a wide signed value to the signed w-bit range
package norm_pkg;

    localparam int N_DEF    = 64;
    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 8;

    localparam logic signed [DW_DEF-1:0] QMAX = {1'b0, {(DW_DEF-1){1'b1}}};
    localparam logic signed [DW_DEF-1:0] QMIN = {1'b1, {(DW_DEF-1){1'b0}}};

    // Width is an argument so lanes built with a non-default DW still clamp correctly.
    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/norm_affine_lane.sv
// norm_affine_lane: one lane of the S1..S4 datapath.
//   S1 p1 = diff*inv_std, S2 a = sat(p1>>>FRAC), S3 p2 = a*gamma (or a),
//   S4 y = sat((p2>>>FRAC)+beta) (or a). Stage loads are driven by the top.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ld1..ld4            per-stage load enables
//   aff_s2, aff_s3      affine enable of the beat held in S2 / S3
//   diff, inv_std,      S0 operands (captured by the top)
//   gamma, beta
//   y                   S4 result
//   sat2, sat4          clamp happened when the held beat was computed in S2 / S4
// Build option: NORM_AFFINE_ROUND_EN adds 2^(FRAC-1) before each >>>FRAC.
module norm_affine_lane
    import norm_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld1,
    input  logic                 ld2,
    input  logic                 ld3,
    input  logic                 ld4,
    input  logic                 aff_s2,
    input  logic                 aff_s3,
    input  logic signed [DW-1:0] diff,
    input  logic        [DW-1:0] inv_std,
    input  logic signed [DW-1:0] gamma,
    input  logic signed [DW-1:0] beta,
    output logic signed [DW-1:0] y,
    output logic                 sat2,
    output logic                 sat4
);

    localparam int PW1 = 2*DW + 1;
    localparam int PW2 = 2*DW;
`ifdef NORM_AFFINE_ROUND_EN
    localparam logic signed [63:0] RND = 64'sd1 <<< (FRAC - 1);
`else
    localparam logic signed [63:0] RND = 64'sd0;
`endif

    logic signed [PW1-1:0] inv_x, diff_x, p1_c, p1;
    logic signed [PW2-1:0] a_x, g_x, p2_c, p2;
    logic signed [DW-1:0]  g1, b1, a2, g2, b2, b3, a2_c, y_c;
    logic signed [63:0]    w2, c2, w4, c4;
    logic                  sat2_c, sat4_c;

    always_comb begin
        // inv_std is unsigned: zero-extend so the product stays signed-correct.
        inv_x  = {{(PW1-DW){1'b0}}, inv_std};
        diff_x = {{(PW1-DW){diff[DW-1]}}, diff};
        p1_c   = inv_x * diff_x;

        w2     = ($signed({{(64-PW1){p1[PW1-1]}}, p1}) + RND) >>> FRAC;
        c2     = sat_dw(w2, DW);
        a2_c   = c2[DW-1:0];
        sat2_c = (c2 != w2);

        a_x    = {{(PW2-DW){a2[DW-1]}}, a2};
        g_x    = {{(PW2-DW){g2[DW-1]}}, g2};
        p2_c   = aff_s2 ? a_x * g_x : a_x;

        w4     = (($signed({{(64-PW2){p2[PW2-1]}}, p2}) + RND) >>> FRAC)
                 + $signed({{(64-DW){b3[DW-1]}}, b3});
        c4     = sat_dw(w4, DW);
        // Bypass beats carry a unchanged in the low bits of p2; no clamp applies.
        y_c    = aff_s3 ? c4[DW-1:0] : p2[DW-1:0];
        sat4_c = aff_s3 && (c4 != w4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1   <= '0;
            g1   <= '0;
            b1   <= '0;
            a2   <= '0;
            g2   <= '0;
            b2   <= '0;
            sat2 <= 1'b0;
            p2   <= '0;
            b3   <= '0;
            y    <= '0;
            sat4 <= 1'b0;
        end else begin
            if (ld1) begin
                p1 <= p1_c;
                g1 <= gamma;
                b1 <= beta;
            end
            if (ld2) begin
                a2   <= a2_c;
                g2   <= g1;
                b2   <= b1;
                sat2 <= sat2_c;
            end
            if (ld3) begin
                p2 <= p2_c;
                b3 <= b2;
            end
            if (ld4) begin
                y    <= y_c;
                sat4 <= sat4_c;
            end
        end
    end

endmodule

// File: rtl/norm_affine_pipe.sv
// norm_affine_pipe: LayerNorm affine back end, N lanes, elastic 5-stage pipe.
//   y = sat(sat((diff*inv_std)>>>FRAC) * gamma >>> FRAC + beta), or the
//   normalized value alone when affine_en=0 for that beat.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake
//   diff_in, gamma_in,       per-lane operands, lane i at [i*DW +: DW]
//   beta_in
//   inv_std, affine_en       per-beat shared operands
//   norm_out, out_valid      result, held stable until out_ready
//   out_ready                downstream accept
//   sat_cnt, sat_clr         saturating clamp-event counter and its clear
// Build option: NORM_AFFINE_ROUND_EN selects round-half-up instead of floor.
module norm_affine_pipe
    import norm_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] diff_in,
    input  logic [DW-1:0]   inv_std,
    input  logic [N*DW-1:0] gamma_in,
    input  logic [N*DW-1:0] beta_in,
    input  logic            affine_en,
    output logic [N*DW-1:0] norm_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     sat_cnt,
    input  logic            sat_clr
);

    logic            v0, v1, v2, v3, v4;
    logic            ld0, ld1, ld2, ld3, ld4;
    logic            aff0, aff1, aff2, aff3;
    logic [N*DW-1:0] d0, g0, b0;
    logic [DW-1:0]   inv0;
    logic [N-1:0]    sat2_vec, sat4_vec;
    logic [15:0]     pop2, pop4, sat_cnt_nx;
    logic [16:0]     inc, sum;

    // Each stage may load when empty or when its successor moves on.
    always_comb begin
        ld4 = !v4 || out_ready;
        ld3 = !v3 || ld4;
        ld2 = !v2 || ld3;
        ld1 = !v1 || ld2;
        ld0 = !v0 || ld1;
    end

    assign in_ready  = ld0;
    assign out_valid = v4;

    for (genvar i = 0; i < N; i++) begin : g_lane
        norm_affine_lane #(
            .DW   (DW),
            .FRAC (FRAC)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .ld1     (ld1),
            .ld2     (ld2),
            .ld3     (ld3),
            .ld4     (ld4),
            .aff_s2  (aff2),
            .aff_s3  (aff3),
            .diff    (d0[i*DW +: DW]),
            .inv_std (inv0),
            .gamma   (g0[i*DW +: DW]),
            .beta    (b0[i*DW +: DW]),
            .y       (norm_out[i*DW +: DW]),
            .sat2    (sat2_vec[i]),
            .sat4    (sat4_vec[i])
        );
    end

    // Events count once as a beat leaves S2 and once as it leaves S4.
    always_comb begin
        pop2 = '0;
        pop4 = '0;
        for (int i = 0; i < N; i++) begin
            pop2 = pop2 + 16'(sat2_vec[i]);
            pop4 = pop4 + 16'(sat4_vec[i]);
        end
        inc        = ((v2 && ld3) ? {1'b0, pop2} : 17'd0)
                   + ((v4 && out_ready) ? {1'b0, pop4} : 17'd0);
        sum        = {1'b0, sat_cnt} + inc;
        sat_cnt_nx = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            v4      <= 1'b0;
            aff0    <= 1'b0;
            aff1    <= 1'b0;
            aff2    <= 1'b0;
            aff3    <= 1'b0;
            d0      <= '0;
            g0      <= '0;
            b0      <= '0;
            inv0    <= '0;
            sat_cnt <= '0;
        end else begin
            if (ld0) begin
                v0   <= in_valid;
                aff0 <= affine_en;
                d0   <= diff_in;
                g0   <= gamma_in;
                b0   <= beta_in;
                inv0 <= inv_std;
            end
            if (ld1) begin
                v1   <= v0;
                aff1 <= aff0;
            end
            if (ld2) begin
                v2   <= v1;
                aff2 <= aff1;
            end
            if (ld3) begin
                v3   <= v2;
                aff3 <= aff2;
            end
            if (ld4) begin
                v4 <= v3;
            end
            // A clear drops any events arriving in the same cycle.
            sat_cnt <= sat_clr ? 16'h0000 : sat_cnt_nx;
        end
    end

endmodule

// File: tb/tb_norm_affine_pipe.sv
module tb_norm_affine_pipe;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int W    = N*DW;
`ifdef NORM_AFFINE_ROUND_EN
    localparam longint RND = 128;
`else
    localparam longint RND = 0;
`endif

    typedef struct {
        logic [W-1:0]  d;
        logic [W-1:0]  g;
        logic [W-1:0]  b;
        logic [DW-1:0] inv;
        logic          aff;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  diff_in = '0;
    logic [DW-1:0] inv_std = '0;
    logic [W-1:0]  gamma_in = '0;
    logic [W-1:0]  beta_in = '0;
    logic          affine_en = 1'b0;
    logic [W-1:0]  norm_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   sat_cnt;
    logic          sat_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sat = 0;
    logic [W-1:0] exp_q[$];

    norm_affine_pipe #(.N(N), .DW(DW), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff_in   (diff_in),
        .inv_std   (inv_std),
        .gamma_in  (gamma_in),
        .beta_in   (beta_in),
        .affine_en (affine_en),
        .norm_out  (norm_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [DW-1:0] inv,
                                 input logic [DW-1:0] g, input logic [DW-1:0] b, input logic aff);
        beat_t bt;
        bt.d = {N{d}};
        bt.g = {N{g}};
        bt.b = {N{b}};
        bt.inv = inv;
        bt.aff = aff;
        return bt;
    endfunction

    function automatic beat_t mk_rand();
        beat_t bt;
        for (int i = 0; i < N; i++) begin
            bt.d[i*DW +: DW] = 16'($urandom_range(0, 65535));
            bt.g[i*DW +: DW] = 16'($urandom_range(0, 4095)) - 16'd2048;
            bt.b[i*DW +: DW] = 16'($urandom_range(0, 65535));
        end
        bt.inv = 16'($urandom_range(0, 1023));
        bt.aff = 1'($urandom_range(0, 1));
        return bt;
    endfunction

    // Reference: plain integer arithmetic on each lane.
    function automatic void model(input beat_t bt, output logic [W-1:0] y, output int ns);
        longint d, inv, g, b, a, r;
        y = '0;
        ns = 0;
        for (int i = 0; i < N; i++) begin
            d   = longint'($signed(bt.d[i*DW +: DW]));
            g   = longint'($signed(bt.g[i*DW +: DW]));
            b   = longint'($signed(bt.b[i*DW +: DW]));
            inv = {48'd0, bt.inv};
            a = (d * inv + RND) >>> FRAC;
            if (a > 32767) begin a = 32767; ns++; end
            else if (a < -32768) begin a = -32768; ns++; end
            if (bt.aff) begin
                r = ((a * g + RND) >>> FRAC) + b;
                if (r > 32767) begin r = 32767; ns++; end
                else if (r < -32768) begin r = -32768; ns++; end
            end else begin
                r = a;
            end
            y[i*DW +: DW] = r[DW-1:0];
        end
    endfunction

    task automatic apply(input beat_t bt);
        diff_in   = bt.d;
        gamma_in  = bt.g;
        beta_in   = bt.b;
        inv_std   = bt.inv;
        affine_en = bt.aff;
    endtask

    // One clock: drive at negedge, sample just after, return after the posedge.
    task automatic cycle(input logic iv, input logic ordy, output logic acc, output logic fire,
                         output logic ov, output logic [W-1:0] dout);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        #1;
        acc  = iv && in_ready;
        ov   = out_valid;
        fire = out_valid && ordy;
        dout = norm_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic a, f, ov;
        logic [W-1:0] d;
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, a, f, ov, d);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (norm_out !== '0) begin n_bad++; $display("FAIL reset_norm_out got=%h want=0", norm_out); end
        n_cmp++; if (sat_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_sat_cnt got=%h want=0", sat_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        logic a, f, ov, got;
        logic [W-1:0] d, dv;
        int lat;
        apply(mk(16'h0100, 16'h0200, 16'h0100, 16'h0080, 1'b1));
        cycle(1'b1, 1'b1, a, f, ov, d);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL lat_accept got=%0b want=1", a); end
        lat = 0; got = 1'b0; dv = '0;
        for (int k = 1; k <= 20 && !got; k++) begin
            cycle(1'b0, 1'b1, a, f, ov, d);
            if (f) begin got = 1'b1; lat = k; dv = d; end
        end
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL lat_cycles got=%0d want=5", lat); end
        n_cmp++; if (dv !== {N{16'h0280}}) begin n_bad++; $display("FAIL lat_data got=%h want=%h", dv, {N{16'h0280}}); end
    endtask

    task automatic test_vectors();
        beat_t bv[4];
        logic [DW-1:0] ev[4];
        logic a, f, ov;
        logic [W-1:0] d, e;
        int sent, guard;
        bv[0] = mk(16'hFF00, 16'h0180, 16'h0000, 16'h0000, 1'b0); ev[0] = 16'hFE80;
        bv[1] = mk(16'h7FFF, 16'h0400, 16'h0000, 16'h0000, 1'b0); ev[1] = 16'h7FFF;
`ifdef NORM_AFFINE_ROUND_EN
        bv[2] = mk(16'h0001, 16'h0080, 16'h0000, 16'h0000, 1'b0); ev[2] = 16'h0001;
`else
        bv[2] = mk(16'h0001, 16'h0080, 16'h0000, 16'h0000, 1'b0); ev[2] = 16'h0000;
`endif
        bv[3] = mk(16'h8000, 16'h0400, 16'h0000, 16'h0000, 1'b0); ev[3] = 16'h8000;
        exp_sat += 2*N;
        sent = 0; guard = 0;
        while ((sent < 4 || exp_q.size() != 0) && guard < 100) begin
            if (sent < 4) apply(bv[sent]);
            cycle(sent < 4, 1'b1, a, f, ov, d);
            if (f) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL vec_extra got=%h", d); end
                else begin
                    e = exp_q.pop_front();
                    if (d !== e) begin n_bad++; $display("FAIL vec_data got=%h want=%h", d, e); end
                end
            end
            if (a) begin exp_q.push_back({N{ev[sent]}}); sent++; end
            guard++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL vec_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
        n_cmp++; if (sat_cnt !== 16'(exp_sat)) begin n_bad++; $display("FAIL vec_sat_cnt got=%0d want=%0d", sat_cnt, exp_sat); end
    endtask

    task automatic test_backpressure();
        beat_t bq[8];
        logic a, f, ov;
        logic [W-1:0] d, e, y;
        int sent, outs, guard, ns;
        for (int k = 0; k < 8; k++) bq[k] = mk_rand();
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            if (sent < 8) apply(bq[sent]);
            cycle(sent < 8, 1'b0, a, f, ov, d);
            if (a) begin model(bq[sent], y, ns); exp_q.push_back(y); exp_sat += ns; sent++; end
        end
        n_cmp++; if (sent != 5) begin n_bad++; $display("FAIL bp_accepted got=%0d want=5", sent); end
        @(negedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || exp_q.size() == 0 || norm_out !== exp_q[0]) begin
            n_bad++; $display("FAIL bp_hold got=%0b/%h", out_valid, norm_out);
        end
        @(posedge clk);
        #1;
        outs = 0; guard = 0;
        while ((sent < 8 || exp_q.size() != 0) && guard < 100) begin
            if (sent < 8) apply(bq[sent]);
            cycle(sent < 8, 1'b1, a, f, ov, d);
            if (f) begin
                n_cmp++; outs++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra got=%h", d); end
                else begin
                    e = exp_q.pop_front();
                    if (d !== e) begin n_bad++; $display("FAIL bp_data got=%h want=%h", d, e); end
                end
            end
            if (a) begin model(bq[sent], y, ns); exp_q.push_back(y); exp_sat += ns; sent++; end
            guard++;
        end
        n_cmp++; if (outs != 8) begin n_bad++; $display("FAIL bp_count got=%0d want=8", outs); exp_q.delete(); end
        n_cmp++; if (sat_cnt !== 16'(exp_sat)) begin n_bad++; $display("FAIL bp_sat_cnt got=%0d want=%0d", sat_cnt, exp_sat); end
    endtask

    task automatic test_random();
        beat_t bt;
        logic a, f, ov, iv, ordy, held;
        logic [W-1:0] d, e, y, held_d;
        int sent, guard, ns, want;
        bt = mk_rand();
        sent = 0; guard = 0; held = 1'b0; held_d = '0;
        while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
            iv   = (sent < 1000) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 1) == 1);
            apply(bt);
            cycle(iv, ordy, a, f, ov, d);
            if (held) begin
                n_cmp++;
                if (ov !== 1'b1 || d !== held_d) begin n_bad++; $display("FAIL rnd_hold got=%0b/%h want=1/%h", ov, d, held_d); end
            end
            held = ov && !ordy;
            held_d = d;
            if (f) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_extra got=%h", d); end
                else begin
                    e = exp_q.pop_front();
                    if (d !== e) begin n_bad++; $display("FAIL rnd_data got=%h want=%h", d, e); end
                end
            end
            if (a) begin model(bt, y, ns); exp_q.push_back(y); exp_sat += ns; sent++; bt = mk_rand(); end
            guard++;
        end
        n_cmp++; if (exp_q.size() != 0 || sent != 1000) begin
            n_bad++; $display("FAIL rnd_drain sent=%0d left=%0d want=1000/0", sent, exp_q.size()); exp_q.delete();
        end
        want = (exp_sat > 65535) ? 65535 : exp_sat;
        n_cmp++; if (sat_cnt !== 16'(want)) begin n_bad++; $display("FAIL rnd_sat_cnt got=%0d want=%0d", sat_cnt, want); end
    endtask

    task automatic test_reset_flight();
        beat_t bs;
        logic a, f, ov;
        logic [W-1:0] d;
        int sent, seen, outs;
        bs = mk(16'h7FFF, 16'h0400, 16'h0000, 16'h0000, 1'b0);
        // Three beats in flight behind a stalled output, the first one saturating.
        sent = 0;
        for (int c = 0; c < 3; c++) begin
            apply(c == 0 ? bs : mk_rand());
            cycle(1'b1, 1'b0, a, f, ov, d);
            if (a) sent++;
        end
        cycle(1'b0, 1'b0, a, f, ov, d);
        n_cmp++; if (sat_cnt !== 16'(exp_sat + N)) begin n_bad++; $display("FAIL rf_pre_sat got=%0d want=%0d", sat_cnt, exp_sat + N); end
        rst = 1'b1;
        cycle(1'b0, 1'b0, a, f, ov, d);
        rst = 1'b0;
        exp_q.delete();
        exp_sat = 0;
        n_cmp++; if (sat_cnt !== 16'h0) begin n_bad++; $display("FAIL rf_sat_cnt got=%h want=0", sat_cnt); end
        n_cmp++; if (norm_out !== '0) begin n_bad++; $display("FAIL rf_norm_out got=%h want=0", norm_out); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b1, a, f, ov, d);
            if (ov) seen++;
        end
        n_cmp++; if (seen != 0 || sent != 3) begin n_bad++; $display("FAIL rf_no_output got=%0d/%0d want=0/3", seen, sent); end

        // Beat A's events land in the cycle before the clear; beat B's coincide with it.
        apply(bs);
        cycle(1'b1, 1'b1, a, f, ov, d);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL clr_accept_a got=%0b want=1", a); end
        cycle(1'b1, 1'b1, a, f, ov, d);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL clr_accept_b got=%0b want=1", a); end
        cycle(1'b0, 1'b1, a, f, ov, d);
        cycle(1'b0, 1'b1, a, f, ov, d);
        n_cmp++; if (sat_cnt !== 16'(N)) begin n_bad++; $display("FAIL clr_before got=%0d want=%0d", sat_cnt, N); end
        sat_clr = 1'b1;
        cycle(1'b0, 1'b1, a, f, ov, d);
        sat_clr = 1'b0;
        n_cmp++; if (sat_cnt !== 16'h0) begin n_bad++; $display("FAIL clr_wins got=%0d want=0", sat_cnt); end
        outs = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b1, a, f, ov, d);
            if (f) begin
                n_cmp++; outs++;
                if (d !== {N{16'h7FFF}}) begin n_bad++; $display("FAIL clr_data got=%h want=%h", d, {N{16'h7FFF}}); end
            end
        end
        n_cmp++; if (outs != 2) begin n_bad++; $display("FAIL clr_count got=%0d want=2", outs); end
        n_cmp++; if (sat_cnt !== 16'h0) begin n_bad++; $display("FAIL clr_after got=%0d want=0", sat_cnt); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_random();
        test_reset_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
